// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with direct-mapped 2-bit BTB prediction, I-cache probe and RUN/MISS/HALT control
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_1000,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_core_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        btb_upd_i,
  input  logic [31:0] btb_upd_pc_i,
  input  logic [31:0] btb_upd_target_i,
  input  logic        btb_upd_taken_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_ready_i,
  input  logic [31:0] icache_data_i,
  input  logic        icache_fault_i,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] fetch_pred_pc_o,
  output logic        fetch_prediction_o,
  output logic        fetch_taken_o,
  output logic        fetch_misaligned_instr_exc_o,
  output logic        fetch_instr_fault_exc_o,
  output logic        fetch_stall_o
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;
  typedef enum logic [1:0] {RUN, MISS, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, pc_inc;
  logic [BTB_ENTRIES-1:0] btb_v;
  logic [TW-1:0] btb_tag [BTB_ENTRIES];
  logic [31:0] btb_tgt [BTB_ENTRIES];
  logic [1:0] btb_ctr [BTB_ENTRIES];
  logic [IDX-1:0] idx, u_idx;
  logic lk_hit, u_hit, req, rsp_ok, unused_upd_lsb;
  assign unused_upd_lsb = ^btb_upd_pc_i[1:0];
  assign idx = pc[IDX+1:2];
  assign u_idx = btb_upd_pc_i[IDX+1:2];
  assign lk_hit = btb_v[idx] && btb_tag[idx] == pc[31:IDX+2];
  assign u_hit = btb_v[u_idx] && btb_tag[u_idx] == btb_upd_pc_i[31:IDX+2];
  assign pc_inc = pc + 32'd4;
  assign req = !rst_i && state != HALT && pc[1:0] == 2'b00;
  assign rsp_ok = req && icache_ready_i && !icache_fault_i;
  assign icache_req_o = req;
  assign icache_addr_o = pc;
  assign fetch_pc_o = pc;
  assign fetch_instr_o = rsp_ok ? icache_data_i : 32'h0000_0013;
  assign fetch_prediction_o = rsp_ok && lk_hit;
  assign fetch_taken_o = rsp_ok && lk_hit && btb_ctr[idx][1];
  assign fetch_pred_pc_o = fetch_taken_o ? btb_tgt[idx] : pc_inc;
  assign fetch_misaligned_instr_exc_o = !rst_i && state == RUN && pc[1:0] != 2'b00;
  assign fetch_instr_fault_exc_o = req && icache_ready_i && icache_fault_i;
  assign fetch_stall_o = req && !icache_ready_i;
  // In RUN/MISS a missing request can only mean a misaligned PC, which halts.
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if (redirect_i) begin
      state_nx = RUN;
      pc_nx = redirect_pc_i;
    end else if (!stall_core_i && state != HALT) begin
      if (!req) state_nx = HALT;
      else if (!icache_ready_i) state_nx = MISS;
      else if (icache_fault_i) state_nx = HALT;
      else begin
        state_nx = RUN;
        pc_nx = fetch_pred_pc_o;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      pc <= RESET_PC;
      btb_v <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      if (btb_upd_i && !u_hit && btb_upd_taken_i) btb_v[u_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (btb_upd_i && u_hit) begin
      btb_ctr[u_idx] <= btb_upd_taken_i ? (btb_ctr[u_idx] == 2'b11 ? 2'b11 : btb_ctr[u_idx] + 2'd1)
                                        : (btb_ctr[u_idx] == 2'b00 ? 2'b00 : btb_ctr[u_idx] - 2'd1);
      if (btb_upd_taken_i) btb_tgt[u_idx] <= btb_upd_target_i;
    end else if (btb_upd_i && btb_upd_taken_i) begin
      btb_ctr[u_idx] <= 2'b10;
      btb_tag[u_idx] <= btb_upd_pc_i[31:IDX+2];
      btb_tgt[u_idx] <= btb_upd_target_i;
    end
  end
endmodule
